reflet_uart_tx_fifo: RTL and testbench
======================================

# reflet_uart_tx_fifo

Bus-mapped transmit buffer that sits directly upstream of the `reflet_uart_uart` transmitter core. It queues bytes written by the CPU and feeds them one at a time to the core's `data_tx`/`start_transmit` inputs. It paces itself on the core's `end_transmit` level, so software can burst up to `depth` bytes without polling between characters. It decodes its own three-register window and drives `data_out` to zero when not addressed, so it ORs cleanly onto the shared read bus.

## Interface
- `base_addr_size`, 16, width of `addr`.
- `base_addr`, 16'hFF1A, address of register offset 0; the window is `base_addr`..`base_addr+2`.
- `depth`, 16, FIFO entries; legal values are 2, 4, 8 and 16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `enable`  in  1  bus select; register access only when high and `addr` is inside the window.
- `addr`  in  `base_addr_size`  bus address.
- `write_en`  in  1  write strobe, sampled on `clk`.
- `data_in`  in  8  write data.
- `data_out`  out  8  read data; combinational; 0 when not addressed.
- `interrupt`  out  1  one-cycle pulse, "transmit drained".
- `data_tx`  out  8  byte presented to the transmitter core; held stable for the whole frame.
- `start_transmit`  out  1  registered request to the core.
- `end_transmit`  in  1  core level, high during the core's stop-bit phase.

## Operation
- Offset 0 DATA:
  - A write pushes `data_in`.
  - A write while full drops the byte and sets `overflow`.
  - Reads return 0.
- Offset 1 STATUS (read-only):
  - bit7 = full, bit6 = empty, bit5 = busy (FSM not IDLE).
  - bits[4:0] = count (0..`depth`).
  - Writes are ignored.
- Offset 2 CTRL:
  - bit0 `irq_en` is read/write; reset value 0.
  - bit1 `flush`: writing 1 empties the FIFO. It is self-clearing and reads 0.
  - bit2 `overflow` is sticky; writing 1 clears it.
  - bits[7:3] read 0.
- The FIFO is circular, with read and write pointers of log2(`depth`) bits plus a separate count. Pointers wrap modulo `depth`.
- The FSM has three states: IDLE, SEND and DRAIN.
  - IDLE: if count > 0, pop the head into the `data_tx` hold register, set `start_transmit` = 1 and go to SEND.
  - SEND: hold `start_transmit` = 1 until `end_transmit` = 1 is sampled. Then clear `start_transmit` and go to DRAIN.
  - DRAIN: wait until `end_transmit` = 0 is sampled, then go to IDLE.
- Push and pop in the same cycle: both take effect and count is unchanged. A push into a full FIFO in a cycle that also pops is accepted.
- Flush:
  - Pointers and count go to 0.
  - A byte already in the hold register finishes its frame (the FSM is unaffected).
  - A push in the same cycle as a flush is discarded without setting `overflow`.
- `interrupt` pulses high for exactly one cycle on the DRAIN→IDLE transition when `irq_en` = 1 and count = 0.
- A simultaneous CTRL write and overflow event: the set wins over the clear.

## Timing
- Reset values:
  - `start_transmit` = 0, `data_tx` = 0, `interrupt` = 0.
  - FSM = IDLE; count, pointers, `irq_en` and `overflow` = 0.
- Reset takes effect at the next edge regardless of state. A reset mid-frame drops the request; the core is reset by the same signal.
- Push latency: a DATA write at edge N into an empty IDLE FIFO → the pop, `data_tx` load and `start_transmit` = 1 are all visible after edge N+1. STATUS count reads 1 between N and N+1, then 0.
- `data_tx` changes only on a pop. It is constant from SEND entry until the next IDLE pop.
- Back-to-back bytes: the next `start_transmit` rises one cycle after `end_transmit` falls, so the core sees it at its next UART tick. The stop bit is not shortened.
- `data_out` is purely combinational from `addr`, `enable` and the register state; it has no read side effects.

## Test plan
- Reset with random bus activity → STATUS = 8'h40, CTRL = 0, `start_transmit` = 0, `data_tx` = 0.
- Write 8'h55 to DATA with a core model attached → `data_tx` = 8'h55 and `start_transmit` = 1 one edge later. On `end_transmit` rising, `start_transmit` = 0. The serial line shows 0, 1,0,1,0,1,0,1,0, 1 at 9600 baud.
- Write `depth`+1 bytes (8'h01..8'h11) while the FSM is in SEND on an earlier byte:
  - STATUS = 8'hB0 (full, busy, count 16).
  - CTRL bit2 = 1.
  - 8'h11 is never transmitted; the others are sent in order.
  - Writing 8'h04 to CTRL clears `overflow`.
- Set `irq_en`, write 3 bytes → exactly one `interrupt` pulse, after the third frame's `end_transmit` falls. There are no pulses between bytes.
- Queue 4 bytes, write CTRL = 8'h02 during the first frame → the first byte completes, count = 0, and no further `start_transmit`.
- Assert reset while in SEND mid-frame → the next cycle has FSM IDLE, `start_transmit` = 0, count 0, and `tx` idles high.

Source files
------------

// File: rtl/reflet_uart_tx_fifo.sv
// Transmit FIFO for the reflet UART core. Queues CPU-written bytes and hands
// them one at a time to the transmitter through data_tx/start_transmit, pacing
// itself on the core's end_transmit level. Exposes a three-register window
// (DATA, STATUS, CTRL) and returns 0 on data_out when not addressed.
module reflet_uart_tx_fifo #(
    parameter int unsigned               base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF1A,
    parameter int unsigned               depth          = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    output logic                      interrupt,
    output logic [7:0]                data_tx,
    output logic                      start_transmit,
    input  logic                      end_transmit
);

    localparam int unsigned PtrW     = $clog2(depth);
    localparam logic [4:0]  DepthCnt = 5'(depth);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSend  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [7:0]      mem [depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]      count_q;
    logic [1:0]      state_q;
    logic            irq_en_q, overflow_q;

    // Address decode: offset is relative to base_addr, window is three registers wide.
    logic [base_addr_size-1:0] offset;
    logic                      hit;
    logic [1:0]                reg_sel;
    assign offset  = addr - base_addr;
    assign hit     = enable && (addr >= base_addr) && (offset <= base_addr_size'(2));
    assign reg_sel = offset[1:0];

    logic wr_data, wr_ctrl, flush, full, empty, busy, pop, push, overflow_set;
    assign wr_data = hit && write_en && (reg_sel == 2'd0);
    assign wr_ctrl = hit && write_en && (reg_sel == 2'd2);
    assign flush   = wr_ctrl && data_in[1];
    assign full    = (count_q == DepthCnt);
    assign empty   = (count_q == 5'd0);
    assign busy    = (state_q != StIdle);
    // A flush empties the queue, so it also cancels a pop in the same cycle.
    assign pop     = (state_q == StIdle) && !empty && !flush;
    // A pop frees a slot, so a push into a full FIFO is accepted in that cycle.
    assign push    = wr_data && !flush && (!full || pop);
    assign overflow_set = wr_data && !flush && full && !pop;

    // Storage array; written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 5'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 5'd1;
            end
        end
    end

    // Control bits; an overflow in the same cycle as a clear leaves overflow set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= data_in[0];
            end
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (wr_ctrl && data_in[2]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Transmit sequencer: pop into the hold register, request, wait for stop bit to end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            data_tx        <= 8'd0;
            start_transmit <= 1'b0;
            interrupt      <= 1'b0;
        end else begin
            interrupt <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        data_tx        <= mem[rd_ptr_q];
                        start_transmit <= 1'b1;
                        state_q        <= StSend;
                    end
                end
                StSend: begin
                    if (end_transmit) begin
                        start_transmit <= 1'b0;
                        state_q        <= StDrain;
                    end
                end
                StDrain: begin
                    if (!end_transmit) begin
                        state_q   <= StIdle;
                        interrupt <= irq_en_q && empty;
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    start_transmit <= 1'b0;
                end
            endcase
        end
    end

    // Read mux; zero when not addressed so it can be ORed onto the bus.
    always_comb begin
        data_out = 8'd0;
        if (hit) begin
            case (reg_sel)
                2'd1:    data_out = {full, empty, busy, count_q};
                2'd2:    data_out = {5'd0, overflow_q, 1'b0, irq_en_q};
                default: data_out = 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_uart_tx_fifo.sv
// Directed bench for reflet_uart_tx_fifo with a small behavioural UART core
// (4 clocks per bit) attached to data_tx/start_transmit/end_transmit.
module tb_reflet_uart_tx_fifo;

    localparam logic [15:0] Base   = 16'hFF1A;
    localparam int          BitClk = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] addr = 16'd0;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic [7:0]  data_out;
    logic        interrupt;
    logic [7:0]  data_tx;
    logic        start_transmit;
    logic        end_transmit;
    logic        tx;

    int n_cmp = 0;
    int n_err = 0;

    reflet_uart_tx_fifo #(
        .base_addr_size(16),
        .base_addr     (16'hFF1A),
        .depth         (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .addr          (addr),
        .write_en      (write_en),
        .data_in       (data_in),
        .data_out      (data_out),
        .interrupt     (interrupt),
        .data_tx       (data_tx),
        .start_transmit(start_transmit),
        .end_transmit  (end_transmit)
    );

    always #5 clk = ~clk;

    // Behavioural transmitter core: start bit, 8 data bits LSB first, stop bit.
    logic       core_busy;
    logic [3:0] core_bit;
    int         core_tick;
    logic [7:0] core_shift;
    logic [7:0] sent_q[$];
    logic       line_q[$];

    always @(posedge clk) begin
        if (!reset) begin
            core_busy    <= 1'b0;
            tx           <= 1'b1;
            end_transmit <= 1'b0;
            core_bit     <= 4'd0;
            core_tick    <= 0;
        end else if (!core_busy) begin
            if (start_transmit) begin
                core_busy  <= 1'b1;
                core_shift <= data_tx;
                core_bit   <= 4'd0;
                core_tick  <= 0;
                tx         <= 1'b0;
                line_q.push_back(1'b0);
            end
        end else if (core_tick == BitClk - 1) begin
            core_tick <= 0;
            if (core_bit == 4'd9) begin
                core_busy    <= 1'b0;
                tx           <= 1'b1;
                end_transmit <= 1'b0;
                sent_q.push_back(core_shift);
            end else begin
                core_bit <= core_bit + 4'd1;
                if (core_bit < 4'd8) begin
                    tx <= core_shift[core_bit[2:0]];
                    line_q.push_back(core_shift[core_bit[2:0]]);
                end else begin
                    tx           <= 1'b1;
                    end_transmit <= 1'b1;
                    line_q.push_back(1'b1);
                end
            end
        end else begin
            core_tick <= core_tick + 1;
        end
    end

    int irq_cnt = 0;
    always @(negedge clk) begin
        if (interrupt) irq_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; addr = a; write_en = 1'b1; data_in = d;
        @(posedge clk);
        #1;
        enable = 1'b0; write_en = 1'b0; addr = 16'd0; data_in = 8'd0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        enable = 1'b1; addr = a; write_en = 1'b0;
        #1;
        d = data_out;
        enable = 1'b0; addr = 16'd0;
    endtask

    task automatic check_reg(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check_eq(tag, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic wait_status(input string tag, input logic [7:0] exp, input int budget);
        logic [7:0] s;
        int n = 0;
        do begin
            @(posedge clk); #1;
            bus_read(Base + 16'd1, s);
            n++;
        end while (s !== exp && n < budget);
        check_eq(tag, {24'd0, s}, {24'd0, exp});
    endtask

    task automatic wait_sent(input string tag, input int target, input int budget);
        int n = 0;
        while (sent_q.size() < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, sent_q.size(), target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         sbase, lbase, ibase, n;
        logic [9:0] exp_line;

        // Reset with random bus activity.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enable   = 1'($urandom);
            write_en = 1'($urandom);
            addr     = Base + 16'($urandom_range(0, 2));
            data_in  = 8'($urandom);
        end
        @(negedge clk);
        enable = 1'b0; write_en = 1'b0; addr = 16'd0; data_in = 8'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reg("reset_status", Base + 16'd1, 8'h40);
        check_reg("reset_ctrl", Base + 16'd2, 8'h00);
        check_eq("reset_start", start_transmit, 1'b0);
        check_eq("reset_data_tx", data_tx, 8'h00);
        check_eq("reset_irq", interrupt, 1'b0);
        check_reg("read_data_reg", Base, 8'h00);

        // Window boundaries: one below and one above read 0 even with CTRL nonzero.
        bus_write(Base + 16'd2, 8'h01);
        check_reg("ctrl_irq_en", Base + 16'd2, 8'h01);
        check_reg("below_window", Base - 16'd1, 8'h00);
        check_reg("above_window", Base + 16'd3, 8'h00);
        bus_write(Base + 16'd2, 8'h00);
        bus_write(Base + 16'd1, 8'hFF);
        check_reg("status_write_ignored", Base + 16'd1, 8'h40);

        // Single byte 0x55: latency, request handshake and line pattern.
        sbase = sent_q.size();
        lbase = line_q.size();
        bus_write(Base, 8'h55);
        check_reg("push_count1", Base + 16'd1, 8'h01);
        check_eq("push_start_pre", start_transmit, 1'b0);
        @(posedge clk); #1;
        check_eq("pop_start", start_transmit, 1'b1);
        check_eq("pop_data_tx", data_tx, 8'h55);
        check_reg("pop_status", Base + 16'd1, 8'h60);
        n = 0;
        while (!end_transmit && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("end_rise_seen", end_transmit, 1'b1);
        check_eq("start_held_at_end", start_transmit, 1'b1);
        @(posedge clk); #1;
        check_eq("start_clear", start_transmit, 1'b0);
        check_eq("data_tx_held", data_tx, 8'h55);
        wait_status("single_idle", 8'h40, 200);
        check_eq("single_sent_n", sent_q.size() - sbase, 1);
        check_eq("single_sent_v", sent_q[sbase], 8'h55);
        exp_line = 10'h2AA;
        check_eq("line_n", line_q.size() - lbase, 10);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("line_bit%0d", i), line_q[lbase + i], exp_line[i]);
        end

        // Overflow: 17 bytes written while an earlier byte is in flight.
        sbase = sent_q.size();
        bus_write(Base, 8'hA0);
        @(posedge clk); #1;
        check_eq("ovf_in_send", start_transmit, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            bus_write(Base, 8'(i));
        end
        check_reg("ovf_status", Base + 16'd1, 8'hB0);
        check_reg("ovf_ctrl", Base + 16'd2, 8'h04);
        bus_write(Base + 16'd2, 8'h04);
        check_reg("ovf_cleared", Base + 16'd2, 8'h00);
        wait_sent("ovf_sent_n", sbase + 17, 2000);
        check_eq("ovf_first", sent_q[sbase], 8'hA0);
        for (int i = 1; i < 17; i++) begin
            check_eq($sformatf("ovf_byte%0d", i), sent_q[sbase + i], 8'(i));
        end
        wait_status("ovf_idle", 8'h40, 200);
        repeat (60) @(posedge clk);
        #1;
        check_eq("ovf_no_0x11", sent_q.size() - sbase, 17);

        // Interrupt: one pulse only after the last of three frames.
        bus_write(Base + 16'd2, 8'h01);
        sbase = sent_q.size();
        ibase = irq_cnt;
        bus_write(Base, 8'h31);
        bus_write(Base, 8'h32);
        bus_write(Base, 8'h33);
        wait_sent("irq_two_sent", sbase + 2, 400);
        repeat (3) @(posedge clk);
        #1;
        check_eq("irq_none_between", irq_cnt - ibase, 0);
        wait_status("irq_idle", 8'h40, 400);
        repeat (5) @(posedge clk);
        #1;
        check_eq("irq_one_pulse", irq_cnt - ibase, 1);
        check_eq("irq_sent3", sent_q[sbase + 2], 8'h33);
        bus_write(Base + 16'd2, 8'h00);

        // Flush during the first of four frames.
        sbase = sent_q.size();
        bus_write(Base, 8'hC1);
        bus_write(Base, 8'hC2);
        bus_write(Base, 8'hC3);
        bus_write(Base, 8'hC4);
        check_reg("flush_pre", Base + 16'd1, 8'h23);
        bus_write(Base + 16'd2, 8'h02);
        check_reg("flush_status", Base + 16'd1, 8'h60);
        check_reg("flush_ctrl", Base + 16'd2, 8'h00);
        check_eq("flush_hold_kept", data_tx, 8'hC1);
        wait_status("flush_idle", 8'h40, 400);
        repeat (80) @(posedge clk);
        #1;
        check_eq("flush_sent_n", sent_q.size() - sbase, 1);
        check_eq("flush_sent_v", sent_q[sbase], 8'hC1);
        check_eq("flush_no_start", start_transmit, 1'b0);

        // Reset mid-frame.
        bus_write(Base, 8'h3C);
        repeat (6) @(posedge clk);
        #1;
        check_eq("mid_in_send", start_transmit, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_start", start_transmit, 1'b0);
        check_eq("mid_rst_data_tx", data_tx, 8'h00);
        check_reg("mid_rst_status", Base + 16'd1, 8'h40);
        check_eq("mid_rst_tx_idle", tx, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("post_rst_quiet", start_transmit, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
